// File: rtl/conv_mem_arbiter.sv
// conv_mem_arbiter: shares one data-memory port between the core LSU (port 0)
// and the convolution accelerator fetch engine (port 1). Fixed priority to
// port 0, with an anti-starvation counter and a per-access watchdog.
module conv_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // port 0: core LSU
    input  logic        p0_rd_i,
    input  logic        p0_wr_i,
    input  logic [31:0] p0_addr_i,
    input  logic [31:0] p0_wdata_i,
    input  logic [3:0]  p0_wstrb_i,
    output logic        p0_ack_o,
    output logic        p0_err_o,
    output logic [31:0] p0_data_o,
    // port 1: accelerator fetch engine (read-only)
    input  logic        p1_rd_i,
    input  logic [31:0] p1_addr_i,
    output logic        p1_ack_o,
    output logic        p1_err_o,
    output logic [31:0] p1_data_o,
    // shared memory port
    output logic        mem_rd_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [1:0]  grant_o
);

    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
    // Counter only ever needs to reach TIMEOUT_CYC-1 before the access ends.
    localparam int unsigned WdW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
    localparam logic [WdW-1:0]     WdLast    = WdW'(TIMEOUT_CYC - 1);
    localparam bit                 WdEn      = (TIMEOUT_CYC != 0);
    localparam logic [31:0]        ErrData   = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

    state_e               r_state, w_state_next;
    logic [StarveW-1:0]   r_starve_cnt, w_starve_next;
    logic [WdW-1:0]       r_wd_cnt, w_wd_next;
    logic                 w_req0, w_req1, w_timeout, w_done;

    // Arbitration, output mux, watchdog and counter next-state logic
    always_comb begin
        w_state_next  = r_state;
        w_starve_next = r_starve_cnt;
        w_wd_next     = r_wd_cnt;
        w_req0        = p0_rd_i | p0_wr_i;
        w_req1        = p1_rd_i;
        w_timeout     = WdEn && (r_wd_cnt == WdLast) && !mem_ack_i;
        w_done        = mem_ack_i | w_timeout;
        grant_o       = 2'b00;
        mem_rd_o      = 1'b0;
        mem_wr_o      = 1'b0;
        mem_addr_o    = 32'h0;
        mem_wdata_o   = 32'h0;
        mem_wstrb_o   = 4'h0;
        p0_ack_o      = 1'b0;
        p0_err_o      = 1'b0;
        p0_data_o     = mem_data_i;
        p1_ack_o      = 1'b0;
        p1_err_o      = 1'b0;
        p1_data_o     = mem_data_i;

        case (r_state)
            StIdle: begin
                if (w_req0 && w_req1) begin
                    w_state_next = (r_starve_cnt == StarveMax) ? StGrant1 : StGrant0;
                end else if (w_req0) begin
                    w_state_next = StGrant0;
                end else if (w_req1) begin
                    w_state_next = StGrant1;
                end
                // Starvation tracking only moves on arbitration decisions.
                if (w_state_next == StGrant1 || !p1_rd_i) begin
                    w_starve_next = '0;
                end else if (w_state_next == StGrant0 && r_starve_cnt != StarveMax) begin
                    w_starve_next = r_starve_cnt + 1'b1;
                end
                w_wd_next = '0;
            end
            StGrant0: begin
                grant_o     = 2'b01;
                mem_rd_o    = p0_rd_i & ~p0_wr_i;
                mem_wr_o    = p0_wr_i;
                mem_addr_o  = p0_addr_i;
                mem_wdata_o = p0_wdata_i;
                mem_wstrb_o = p0_wstrb_i;
                p0_ack_o    = w_done;
                p0_err_o    = w_timeout;
                if (w_timeout) p0_data_o = ErrData;
                if (w_done) w_state_next = StIdle;
                if (!mem_ack_i) w_wd_next = r_wd_cnt + 1'b1;
            end
            StGrant1: begin
                grant_o     = 2'b10;
                mem_rd_o    = p1_rd_i;
                mem_addr_o  = p1_addr_i;
                p1_ack_o    = w_done;
                p1_err_o    = w_timeout;
                if (w_timeout) p1_data_o = ErrData;
                if (w_done) w_state_next = StIdle;
                if (!mem_ack_i) w_wd_next = r_wd_cnt + 1'b1;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State and counter registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= StIdle;
            r_starve_cnt <= '0;
            r_wd_cnt     <= '0;
        end else begin
            r_state      <= w_state_next;
            r_starve_cnt <= w_starve_next;
            r_wd_cnt     <= w_wd_next;
        end
    end

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// Directed self-checking bench for conv_mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYC=8).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_conv_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_rd, p0_wr;
    logic [31:0] p0_addr, p0_wdata;
    logic [3:0]  p0_wstrb;
    logic        p0_ack, p0_err;
    logic [31:0] p0_data;
    logic        p1_rd;
    logic [31:0] p1_addr;
    logic        p1_ack, p1_err;
    logic [31:0] p1_data;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [1:0]  grant;

    int n_vec = 0;
    int n_err = 0;
    int p1_acks = 0;

    conv_mem_arbiter #(
        .STARVE_LIMIT(4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .p0_rd_i    (p0_rd),
        .p0_wr_i    (p0_wr),
        .p0_addr_i  (p0_addr),
        .p0_wdata_i (p0_wdata),
        .p0_wstrb_i (p0_wstrb),
        .p0_ack_o   (p0_ack),
        .p0_err_o   (p0_err),
        .p0_data_o  (p0_data),
        .p1_rd_i    (p1_rd),
        .p1_addr_i  (p1_addr),
        .p1_ack_o   (p1_ack),
        .p1_err_o   (p1_err),
        .p1_data_o  (p1_data),
        .mem_rd_o   (mem_rd),
        .mem_wr_o   (mem_wr),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_wstrb_o(mem_wstrb),
        .mem_ack_i  (mem_ack),
        .mem_data_i (mem_data),
        .grant_o    (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge (middle of a cycle).
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; p0_rd = 0; p0_wr = 0; p0_addr = 0; p0_wdata = 0; p0_wstrb = 0;
        p1_rd = 0; p1_addr = 0; mem_ack = 0; mem_data = 0;

        // ---- reset state
        repeat (3) cyc();
        settle();
        chk("rst_grant", {30'h0, grant}, 32'h0);
        chk("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_acks", {28'h0, p0_ack, p0_err, p1_ack, p1_err}, 32'h0);

        // ---- single port-1 read, ack after 3 cycles
        cyc(); rst_n = 1'b1; p1_rd = 1'b1; p1_addr = 32'h40; settle();   // cycle 0
        chk("t1_c0_grant", {30'h0, grant}, 32'h0);
        chk("t1_c0_mem_rd", {31'h0, mem_rd}, 32'h0);
        cyc(); settle();                                                 // cycle 1
        chk("t1_c1_grant", {30'h0, grant}, 32'h2);
        chk("t1_c1_mem_rd", {31'h0, mem_rd}, 32'h1);
        chk("t1_c1_mem_wr", {31'h0, mem_wr}, 32'h0);
        chk("t1_c1_addr", mem_addr, 32'h40);
        chk("t1_c1_p1_ack", {31'h0, p1_ack}, 32'h0);
        cyc(); settle();                                                 // cycle 2
        chk("t1_c2_p1_ack", {31'h0, p1_ack}, 32'h0);
        cyc(); settle();                                                 // cycle 3
        chk("t1_c3_mem_rd", {31'h0, mem_rd}, 32'h1);
        cyc(); mem_ack = 1'b1; mem_data = 32'h1234_5678; settle();       // cycle 4
        chk("t1_c4_p1_ack", {31'h0, p1_ack}, 32'h1);
        chk("t1_c4_p1_err", {31'h0, p1_err}, 32'h0);
        chk("t1_c4_p1_data", p1_data, 32'h1234_5678);
        chk("t1_c4_p0_ack", {31'h0, p0_ack}, 32'h0);
        cyc(); mem_ack = 1'b0; p1_rd = 1'b0; settle();                   // cycle 5
        chk("t1_c5_grant", {30'h0, grant}, 32'h0);
        chk("t1_c5_p1_ack", {31'h0, p1_ack}, 32'h0);

        // ---- both ports continuously, L = 0: grants 0,0,0,0,1 repeating
        p0_addr = 32'h200; p1_addr = 32'h300;
        for (int k = 0; k < 10; k++) begin
            cyc(); p0_rd = 1'b1; p1_rd = 1'b1; mem_ack = 1'b1; mem_data = 32'h1000 + k;
            settle();
            chk($sformatf("st%0d_idle_grant", k), {30'h0, grant}, 32'h0);
            cyc(); settle();
            if (k % 5 == 4) begin
                chk($sformatf("st%0d_grant", k), {30'h0, grant}, 32'h2);
                chk($sformatf("st%0d_addr", k), mem_addr, 32'h300);
            end else begin
                chk($sformatf("st%0d_grant", k), {30'h0, grant}, 32'h1);
                chk($sformatf("st%0d_addr", k), mem_addr, 32'h200);
            end
            chk($sformatf("st%0d_p0_ack", k), {31'h0, p0_ack}, (k % 5 == 4) ? 32'h0 : 32'h1);
            if (p1_ack) p1_acks++;
        end
        chk("st_p1_ack_count", p1_acks, 32'd2);
        cyc(); p0_rd = 1'b0; p1_rd = 1'b0; mem_ack = 1'b0; settle();
        chk("st_end_grant", {30'h0, grant}, 32'h0);

        // ---- port-0 write with rd and wr both high
        cyc(); p0_rd = 1'b1; p0_wr = 1'b1; p0_addr = 32'h100;
        p0_wdata = 32'hA5A5_A5A5; p0_wstrb = 4'b0011; settle();
        chk("wr_idle_mem_wr", {31'h0, mem_wr}, 32'h0);
        cyc(); settle();
        chk("wr_grant", {30'h0, grant}, 32'h1);
        chk("wr_mem_wr", {31'h0, mem_wr}, 32'h1);
        chk("wr_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("wr_addr", mem_addr, 32'h100);
        chk("wr_wdata", mem_wdata, 32'hA5A5_A5A5);
        chk("wr_wstrb", {28'h0, mem_wstrb}, 32'h3);
        chk("wr_noack", {31'h0, p0_ack}, 32'h0);
        cyc(); mem_ack = 1'b1; settle();
        chk("wr_p0_ack", {31'h0, p0_ack}, 32'h1);
        chk("wr_p0_err", {31'h0, p0_err}, 32'h0);
        cyc(); mem_ack = 1'b0; p0_rd = 1'b0; p0_wr = 1'b0; settle();
        chk("wr_end_grant", {30'h0, grant}, 32'h0);

        // ---- port-1 timeout, TIMEOUT_CYC = 8
        cyc(); p1_rd = 1'b1; p1_addr = 32'h80; mem_data = 32'h1111_1111; settle(); // cycle 0
        for (int c = 1; c < 8; c++) begin
            cyc(); settle();
            chk($sformatf("to_c%0d_grant", c), {30'h0, grant}, 32'h2);
            chk($sformatf("to_c%0d_p1_ack", c), {31'h0, p1_ack}, 32'h0);
        end
        cyc(); settle();                                                 // cycle 8
        chk("to_c8_p1_ack", {31'h0, p1_ack}, 32'h1);
        chk("to_c8_p1_err", {31'h0, p1_err}, 32'h1);
        chk("to_c8_p1_data", p1_data, 32'hDEAD_BEEF);
        chk("to_c8_p0_ack", {31'h0, p0_ack}, 32'h0);
        cyc(); p1_rd = 1'b0; settle();                                   // cycle 9
        chk("to_c9_grant", {30'h0, grant}, 32'h0);
        cyc(); mem_ack = 1'b1; settle();                                 // stray ack
        chk("to_stray_acks", {28'h0, p0_ack, p0_err, p1_ack, p1_err}, 32'h0);
        chk("to_stray_grant", {30'h0, grant}, 32'h0);
        cyc(); mem_ack = 1'b0; settle();

        // ---- reset mid-GRANT0
        cyc(); p0_rd = 1'b1; p0_addr = 32'h10; settle();
        cyc(); settle();
        chk("rs_grant0", {30'h0, grant}, 32'h1);
        cyc(); rst_n = 1'b0; settle();
        cyc(); rst_n = 1'b1; mem_ack = 1'b1; settle();
        chk("rs_after_grant", {30'h0, grant}, 32'h0);
        chk("rs_after_mem_rd", {31'h0, mem_rd}, 32'h0);
        chk("rs_after_addr", mem_addr, 32'h0);
        chk("rs_after_p0_ack", {31'h0, p0_ack}, 32'h0);
        cyc(); mem_ack = 1'b0; settle();
        chk("rs_fresh_grant", {30'h0, grant}, 32'h1);
        chk("rs_fresh_mem_rd", {31'h0, mem_rd}, 32'h1);
        cyc(); mem_ack = 1'b1; mem_data = 32'hCAFE_F00D; settle();
        chk("rs_fresh_p0_ack", {31'h0, p0_ack}, 32'h1);
        chk("rs_fresh_p0_data", p0_data, 32'hCAFE_F00D);
        cyc(); mem_ack = 1'b0; p0_rd = 1'b0; settle();
        chk("rs_end_grant", {30'h0, grant}, 32'h0);

        // ---- mem_ack in IDLE with no request
        cyc(); mem_ack = 1'b1; settle();
        chk("ia_acks", {28'h0, p0_ack, p0_err, p1_ack, p1_err}, 32'h0);
        chk("ia_grant", {30'h0, grant}, 32'h0);
        cyc(); mem_ack = 1'b0; settle();
        chk("ia_after_grant", {30'h0, grant}, 32'h0);
        chk("ia_after_mem_rd", {31'h0, mem_rd}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
